// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the MO-stage pipeline port and a debug/DMA port.
// Debug gets idle slots, a forced slot after STARVE_LIMIT denied cycles, or a locked burst.
module dmem_arbiter #(
    parameter int AW           = 24,
    parameter int DW           = 24,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p_req,
    input  logic          p_we,
    input  logic [AW-1:0] p_addr,
    input  logic [DW-1:0] p_wdata,
    output logic          p_stall,
    output logic [DW-1:0] p_rdata,
    output logic          p_rvalid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic          d_lock,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic [DW-1:0] d_rdata,
    output logic          d_rvalid,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic {ARB = 1'b0, DLOCK = 1'b1} state_e;
    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_P = 2'd1, OWN_D = 2'd2} owner_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_e        state_q, state_d;
    owner_e        rd_owner_q, rd_owner_d;
    logic [3:0]    wait_cnt_q, wait_cnt_d;
    logic [DW-1:0] p_hold_q, p_hold_d;
    logic [DW-1:0] d_hold_q, d_hold_d;
    logic [3:0]    eff_wait_s;
    logic          locked_s;
    logic          grant_p_s;
    logic          grant_d_s;

    // Arbitration, lock FSM and starvation counter.
    always_comb begin
        state_d    = state_q;
        eff_wait_s = wait_cnt_q;
        locked_s   = 1'b0;
        grant_p_s  = 1'b0;
        grant_d_s  = 1'b0;
        case (state_q)
            ARB: begin
                eff_wait_s = wait_cnt_q;
            end
            DLOCK: begin
                // The cycle that leaves the burst is arbitrated fresh, so the pipeline wins it.
                if (d_req && d_lock) begin
                    locked_s = 1'b1;
                end else begin
                    state_d    = ARB;
                    eff_wait_s = 4'd0;
                end
            end
            default: begin
                state_d    = ARB;
                eff_wait_s = 4'd0;
            end
        endcase

        if (locked_s) begin
            grant_d_s = 1'b1;
        end else if (d_req && (!p_req || eff_wait_s == LIMIT)) begin
            grant_d_s = 1'b1;
            if (d_lock) begin
                state_d = DLOCK;
            end else begin
                state_d = ARB;
            end
        end else begin
            grant_p_s = p_req;
        end

        if (grant_d_s || !d_req) begin
            wait_cnt_d = 4'd0;
        end else if (eff_wait_s >= LIMIT) begin
            wait_cnt_d = LIMIT;
        end else begin
            wait_cnt_d = eff_wait_s + 4'd1;
        end
    end

    // Memory pin steering and read-ownership bookkeeping.
    always_comb begin
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = {AW{1'b0}};
        mem_wdata  = {DW{1'b0}};
        rd_owner_d = OWN_NONE;
        if (grant_d_s) begin
            mem_en     = 1'b1;
            mem_we     = d_we;
            mem_addr   = d_addr;
            mem_wdata  = d_wdata;
            rd_owner_d = d_we ? OWN_NONE : OWN_D;
        end else if (grant_p_s) begin
            mem_en     = 1'b1;
            mem_we     = p_we;
            mem_addr   = p_addr;
            mem_wdata  = p_wdata;
            rd_owner_d = p_we ? OWN_NONE : OWN_P;
        end else begin
            rd_owner_d = OWN_NONE;
        end

        p_hold_d = (rd_owner_q == OWN_P) ? mem_rdata : p_hold_q;
        d_hold_d = (rd_owner_q == OWN_D) ? mem_rdata : d_hold_q;
    end

    // State, counter, owner and read-data hold registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB;
            wait_cnt_q <= 4'd0;
            rd_owner_q <= OWN_NONE;
            p_hold_q   <= {DW{1'b0}};
            d_hold_q   <= {DW{1'b0}};
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rd_owner_q <= rd_owner_d;
            p_hold_q   <= p_hold_d;
            d_hold_q   <= d_hold_d;
        end
    end

    assign p_stall  = p_req && !grant_p_s;
    assign d_gnt    = grant_d_s;
    assign p_rvalid = (rd_owner_q == OWN_P);
    assign d_rvalid = (rd_owner_q == OWN_D);
    assign p_rdata  = p_rvalid ? mem_rdata : p_hold_q;
    assign d_rdata  = d_rvalid ? mem_rdata : d_hold_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a one-cycle-latency memory model.
module tb_dmem_arbiter;

    localparam int AW = 24;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          p_req, p_we, d_req, d_we, d_lock;
    logic [AW-1:0] p_addr, d_addr;
    logic [DW-1:0] p_wdata, d_wdata;
    logic          p_stall, p_rvalid, d_gnt, d_rvalid;
    logic [DW-1:0] p_rdata, d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] mem [0:255];

    int n_checks = 0;
    int n_pass   = 0;

    dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_stall(p_stall), .p_rdata(p_rdata), .p_rvalid(p_rvalid),
        .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory, read data one cycle after the strobe.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic set_p(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        p_req = req; p_we = we; p_addr = a; p_wdata = wd;
    endtask

    task automatic set_d(input logic req, input logic we, input logic lk, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        d_req = req; d_we = we; d_lock = lk; d_addr = a; d_wdata = wd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 24'h0;
        mem[8'h20] = 24'h111111;
        mem[8'h21] = 24'h222222;
        mem_rdata = 24'h0;
        rst = 1'b1;
        set_p(1'b0, 1'b0, 24'h0, 24'h0);
        set_d(1'b0, 1'b0, 1'b0, 24'h0, 24'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_p_rdata",  32'(p_rdata), 32'h0);
        check("rst_d_rdata",  32'(d_rdata), 32'h0);
        check("rst_p_rvalid", 32'(p_rvalid), 32'h0);
        check("rst_d_rvalid", 32'(d_rvalid), 32'h0);
        check("rst_mem_en",   32'(mem_en), 32'h0);
        check("rst_wait",     32'(dut.wait_cnt_q), 32'h0);
        next_cycle();

        // Idle
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle_mem_en",  32'(mem_en), 32'h0);
            check("idle_mem_we",  32'(mem_we), 32'h0);
            check("idle_p_stall", 32'(p_stall), 32'h0);
            check("idle_d_gnt",   32'(d_gnt), 32'h0);
            check("idle_wait",    32'(dut.wait_cnt_q), 32'h0);
            next_cycle();
        end

        // Pipeline store then load of 0x10
        set_p(1'b1, 1'b1, 24'h000010, 24'hABCDEF);
        @(negedge clk);
        check("pw_mem_en",    32'(mem_en), 32'h1);
        check("pw_mem_we",    32'(mem_we), 32'h1);
        check("pw_mem_addr",  32'(mem_addr), 32'h10);
        check("pw_mem_wdata", 32'(mem_wdata), 32'hABCDEF);
        check("pw_p_stall",   32'(p_stall), 32'h0);
        next_cycle();
        set_p(1'b1, 1'b0, 24'h000010, 24'h0);
        @(negedge clk);
        check("pr_mem_en",    32'(mem_en), 32'h1);
        check("pr_mem_we",    32'(mem_we), 32'h0);
        check("pr_p_stall",   32'(p_stall), 32'h0);
        check("pr_p_rvalid0", 32'(p_rvalid), 32'h0);
        next_cycle();
        set_p(1'b0, 1'b0, 24'h0, 24'h0);
        @(negedge clk);
        check("pr_p_rvalid1", 32'(p_rvalid), 32'h1);
        check("pr_p_rdata",   32'(p_rdata), 32'hABCDEF);
        check("pr_d_rvalid",  32'(d_rvalid), 32'h0);
        next_cycle();
        @(negedge clk);
        check("pr_p_rvalid2", 32'(p_rvalid), 32'h0);
        check("pr_p_hold",    32'(p_rdata), 32'hABCDEF);
        next_cycle();

        // Starvation: pipeline stores vs debug read, debug forced on cycle 4
        set_p(1'b1, 1'b1, 24'h000030, 24'h000555);
        set_d(1'b1, 1'b0, 1'b0, 24'h000021, 24'h0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("st_d_gnt",    32'(d_gnt), (c == 4) ? 32'h1 : 32'h0);
            check("st_p_stall",  32'(p_stall), (c == 4) ? 32'h1 : 32'h0);
            check("st_mem_addr", 32'(mem_addr), (c == 4) ? 32'h21 : 32'h30);
            check("st_wait",     32'(dut.wait_cnt_q), (c <= 4) ? 32'(c) : 32'h0);
            check("st_d_rvalid", 32'(d_rvalid), (c == 5) ? 32'h1 : 32'h0);
            if (c == 5) check("st_d_rdata", 32'(d_rdata), 32'h222222);
            next_cycle();
        end
        set_p(1'b0, 1'b0, 24'h0, 24'h0);
        set_d(1'b0, 1'b0, 1'b0, 24'h0, 24'h0);
        next_cycle();

        // Lock burst: 4 pipeline cycles build the forced slot, then 6 locked debug writes
        set_p(1'b1, 1'b1, 24'h000031, 24'h000005);
        set_d(1'b1, 1'b1, 1'b1, 24'h000022, 24'h777777);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("lk_d_gnt",   32'(d_gnt), (c >= 4) ? 32'h1 : 32'h0);
            check("lk_p_stall", 32'(p_stall), (c >= 4) ? 32'h1 : 32'h0);
            check("lk_state",   32'(dut.state_q), (c >= 5) ? 32'h1 : 32'h0);
            if (c >= 4) check("lk_mem_addr", 32'(mem_addr), 32'h22);
            next_cycle();
        end
        d_lock = 1'b0;
        @(negedge clk);
        check("unlk_d_gnt",    32'(d_gnt), 32'h0);
        check("unlk_p_stall",  32'(p_stall), 32'h0);
        check("unlk_mem_addr", 32'(mem_addr), 32'h31);
        next_cycle();
        set_p(1'b0, 1'b0, 24'h0, 24'h0);
        set_d(1'b0, 1'b0, 1'b0, 24'h0, 24'h0);
        @(negedge clk);
        check("unlk_state", 32'(dut.state_q), 32'h0);
        next_cycle();

        // Read steering: pipeline read 0x20 then debug read 0x21
        set_p(1'b1, 1'b0, 24'h000020, 24'h0);
        @(negedge clk);
        check("rs_p_stall", 32'(p_stall), 32'h0);
        next_cycle();
        set_p(1'b0, 1'b0, 24'h0, 24'h0);
        set_d(1'b1, 1'b0, 1'b0, 24'h000021, 24'h0);
        @(negedge clk);
        check("rs_d_gnt",     32'(d_gnt), 32'h1);
        check("rs_p_rvalid",  32'(p_rvalid), 32'h1);
        check("rs_p_rdata",   32'(p_rdata), 32'h111111);
        check("rs_d_rvalid0", 32'(d_rvalid), 32'h0);
        next_cycle();
        set_d(1'b0, 1'b0, 1'b0, 24'h0, 24'h0);
        @(negedge clk);
        check("rs_d_rvalid1", 32'(d_rvalid), 32'h1);
        check("rs_d_rdata",   32'(d_rdata), 32'h222222);
        check("rs_p_rvalid2", 32'(p_rvalid), 32'h0);
        check("rs_p_hold",    32'(p_rdata), 32'h111111);
        next_cycle();

        // Reset mid-read: pipeline read with debug denied, then reset
        set_p(1'b1, 1'b0, 24'h000020, 24'h0);
        set_d(1'b1, 1'b0, 1'b0, 24'h000021, 24'h0);
        @(negedge clk);
        check("rm_p_stall", 32'(p_stall), 32'h0);
        next_cycle();
        rst = 1'b1;
        set_p(1'b0, 1'b0, 24'h0, 24'h0);
        set_d(1'b0, 1'b0, 1'b0, 24'h0, 24'h0);
        #1;
        check("rm_p_rvalid", 32'(p_rvalid), 32'h0);
        check("rm_p_rdata",  32'(p_rdata), 32'h0);
        check("rm_d_rdata",  32'(d_rdata), 32'h0);
        check("rm_state",    32'(dut.state_q), 32'h0);
        check("rm_wait",     32'(dut.wait_cnt_q), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
        @(negedge clk);
        check("rm_p_rvalid_after", 32'(p_rvalid), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
